intc_irq_scheduler: RTL and testbench

//  Core sequencer of the interrupt controller. Latches rising edges on 4 interrupt sources.

---
 rtl/intc_irq_scheduler.sv | 121 ++++++++++++
 tb/tb_intc_irq_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_irq_scheduler.sv
// Interrupt sequencer: edge-latched pending flags, round-robin arbitration, req/ack/eoi CPU handshake.
// Edge at clock n sets pending at n, and intr_req rises at n+1; the request stays up until intr_ack.
module intc_irq_scheduler #(
   parameter int                 NUM_SRC   = 4,
   parameter int                 DATA_W    = 32,
   parameter logic [DATA_W-1:0]  RESET_ISR = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_in,
   input  logic                bus_we,
   input  logic [31:0]         bus_addr,
   input  logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W-1:0]   bus_rdata,
   output logic                intr_req,
   output logic [1:0]          intr_id,
   output logic [DATA_W-1:0]   intr_vector,
   input  logic                intr_ack,
   input  logic                intr_eoi,
   output logic [NUM_SRC-1:0]  pending
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t              state;
   logic [NUM_SRC-1:0]  irq_prev;
   logic [NUM_SRC-1:0]  mask;
   logic [DATA_W-1:0]   isr [NUM_SRC];
   logic [1:0]          rr_ptr;

   logic [NUM_SRC-1:0]  cand;
   logic [NUM_SRC-1:0]  edge_set;
   logic [NUM_SRC-1:0]  ack_clr;
   logic [1:0]          winner;
   logic                win_vld;
   logic [1:0]          idx;
   logic                unused_addr;

   assign unused_addr = ^{bus_addr[31:5], bus_addr[1:0]};

   assign cand     = pending & mask;
   assign edge_set = irq_in & ~irq_prev;

   always_comb begin
      ack_clr = '0;
      if (state == REQ && intr_ack)
         ack_clr[intr_id] = 1'b1;
   end

   // Search starts just after the last acked source so every source gets a turn.
   always_comb begin
      win_vld = 1'b0;
      winner  = rr_ptr;
      idx     = rr_ptr;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = rr_ptr + 2'(k);
         if (!win_vld && cand[idx]) begin
            win_vld = 1'b1;
            winner  = idx;
         end
      end
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_addr[4])
         bus_rdata[NUM_SRC-1:0] = mask;
      else
         bus_rdata = isr[bus_addr[3:2]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         irq_prev    <= '0;
         pending     <= '0;
         mask        <= '0;
         rr_ptr      <= 2'd3;
         intr_req    <= 1'b0;
         intr_id     <= 2'd0;
         intr_vector <= '0;
         for (int i = 0; i < NUM_SRC; i++)
            isr[i] <= RESET_ISR;
      end else begin
         irq_prev <= irq_in;
         // A new edge on the source being acked must not be lost.
         pending  <= (pending & ~ack_clr) | edge_set;

         if (bus_we) begin
            if (bus_addr[4])
               mask <= bus_wdata[NUM_SRC-1:0];
            else
               isr[bus_addr[3:2]] <= bus_wdata;
         end

         case (state)
            IDLE: begin
               if (win_vld) begin
                  intr_id     <= winner;
                  intr_vector <= isr[winner];
                  intr_req    <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (intr_ack) begin
                  rr_ptr   <= intr_id;
                  intr_req <= 1'b0;
                  state    <= SERVICE;
               end
            end
            SERVICE: begin
               if (intr_eoi)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intc_irq_scheduler.sv
// Scoreboarded bench for intc_irq_scheduler: expected grants are queued as edges are driven
// and popped when intr_req rises.
module tb_intc_irq_scheduler;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] vec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  irq_in;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        intr_req;
   logic [1:0]  intr_id;
   logic [31:0] intr_vector;
   logic        intr_ack;
   logic        intr_eoi;
   logic [3:0]  pending;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t sb[$];

   logic [31:0] isr_init [4] = '{32'h0000_1000, 32'h0000_2000, 32'h0002_0040, 32'h0000_4000};

   intc_irq_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .irq_in      (irq_in),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .intr_req    (intr_req),
      .intr_id     (intr_id),
      .intr_vector (intr_vector),
      .intr_ack    (intr_ack),
      .intr_eoi    (intr_eoi),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] id);
      exp_t e;
      e.id  = id;
      e.vec = isr_init[id];
      sb.push_back(e);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus_we    = 1'b1;
      bus_addr  = a;
      bus_wdata = d;
      step();
      bus_we    = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] e);
      bus_addr = a;
      #1;
      chk(tag, bus_rdata, e);
   endtask

   task automatic init(input logic [3:0] m);
      irq_in   = '0;
      intr_ack = 1'b0;
      intr_eoi = 1'b0;
      bus_we   = 1'b0;
      bus_addr = '0;
      bus_wdata = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++)
         bus_write(32'(i * 4), isr_init[i]);
      bus_write(32'h10, {28'b0, m});
   endtask

   task automatic pulse(input logic [3:0] v);
      irq_in = v;
      step();
      irq_in = '0;
   endtask

   task automatic wait_req(input int max_cyc);
      exp_t e;
      int   i;
      i = 0;
      while (!intr_req && i < max_cyc) begin
         step();
         i++;
      end
      chk("req_seen", {31'b0, intr_req}, 32'd1);
      if (sb.size() == 0) begin
         chk("sb_underflow", sb.size(), 32'd1);
      end else begin
         e = sb.pop_front();
         chk("grant_id", {30'b0, intr_id}, {30'b0, e.id});
         chk("grant_vec", intr_vector, e.vec);
      end
   endtask

   task automatic do_ack();
      logic [3:0] bit_id;
      bit_id = 4'b0001 << intr_id;
      intr_ack = 1'b1;
      step();
      intr_ack = 1'b0;
      chk("ack_req_low", {31'b0, intr_req}, 32'd0);
      chk("ack_clr_pend", {31'b0, |(pending & bit_id)}, 32'd0);
   endtask

   task automatic serve();
      do_ack();
      intr_eoi = 1'b1;
      step();
      intr_eoi = 1'b0;
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      irq_in = '0; intr_ack = 1'b0; intr_eoi = 1'b0;
      bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      step();
      chk("rst_req", {31'b0, intr_req}, 32'd0);
      chk("rst_id", {30'b0, intr_id}, 32'd0);
      chk("rst_vec", intr_vector, 32'd0);
      chk("rst_pend", {28'b0, pending}, 32'd0);
      bus_read("rst_mask", 32'h10, 32'd0);
      bus_read("rst_isr2", 32'h8, 32'd0);
      rst = 1'b0;

      // single source, exact latency
      init(4'hF);
      push(2);
      irq_in = 4'b0100;
      step();
      chk("t1_pend", {28'b0, pending}, 32'h4);
      chk("t1_req_early", {31'b0, intr_req}, 32'd0);
      irq_in = '0;
      step();
      chk("t1_req_lat", {31'b0, intr_req}, 32'd1);
      wait_req(0);
      serve();

      // all four at once, round-robin from reset priority, twice
      init(4'hF);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) push(2'(i));
         pulse(4'hF);
         for (int i = 0; i < 4; i++) begin
            wait_req(8);
            serve();
         end
      end

      // masked sources stay pending; after unmasking, rr_ptr=2 puts 3 ahead of 1
      init(4'b0101);
      push(0);
      push(2);
      pulse(4'hF);
      for (int i = 0; i < 2; i++) begin
         wait_req(8);
         serve();
      end
      step();
      step();
      chk("t3_pend", {28'b0, pending}, 32'hA);
      chk("t3_no_req", {31'b0, intr_req}, 32'd0);
      bus_write(32'h10, 32'hF);
      push(3);
      push(1);
      for (int i = 0; i < 2; i++) begin
         wait_req(8);
         serve();
      end

      // register writes while in REQ do not disturb the request
      init(4'hF);
      push(1);
      pulse(4'b0010);
      wait_req(8);
      bus_write(32'h4, 32'hDEAD_0000);
      bus_write(32'h10, 32'h0);
      step();
      chk("t4_req_held", {31'b0, intr_req}, 32'd1);
      chk("t4_id_held", {30'b0, intr_id}, 32'd1);
      chk("t4_vec_held", intr_vector, isr_init[1]);
      bus_read("t4_isr1_rd", 32'h4, 32'hDEAD_0000);
      bus_read("t4_mask_rd", 32'h10, 32'h0);
      serve();

      // edge during SERVICE waits for eoi; a held level makes no new request
      init(4'hF);
      push(0);
      pulse(4'b0001);
      wait_req(8);
      do_ack();
      irq_in = 4'b0001;
      step();
      chk("t5_pend", {28'b0, pending}, 32'h1);
      step();
      step();
      chk("t5_no_nest", {31'b0, intr_req}, 32'd0);
      push(0);
      intr_eoi = 1'b1;
      step();
      intr_eoi = 1'b0;
      chk("t5_eoi_idle", {31'b0, intr_req}, 32'd0);
      step();
      wait_req(0);
      serve();
      repeat (4) step();
      chk("t5_level_req", {31'b0, intr_req}, 32'd0);
      chk("t5_level_pend", {28'b0, pending}, 32'd0);
      irq_in = '0;

      // register reads with aliases, then reset in REQ
      init(4'hF);
      bus_write(32'h10, 32'hB);
      for (int i = 0; i < 4; i++)
         bus_read("t6_isr_rd", 32'(i * 4), isr_init[i]);
      bus_read("t6_mask_rd", 32'h10, 32'hB);
      bus_read("t6_alias0", 32'h1, isr_init[0]);
      bus_read("t6_alias1", 32'h26, isr_init[1]);
      bus_read("t6_alias_m", 32'h33, 32'hB);
      push(3);
      pulse(4'b1000);
      wait_req(8);
      rst = 1'b1;
      #1;
      chk("t6_rst_req", {31'b0, intr_req}, 32'd0);
      chk("t6_rst_pend", {28'b0, pending}, 32'd0);
      chk("t6_rst_vec", intr_vector, 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++)
         bus_read("t6_rst_isr", 32'(i * 4), 32'd0);
      bus_read("t6_rst_mask", 32'h10, 32'd0);
      step();
      chk("t6_idle_req", {31'b0, intr_req}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
